// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: addresses a combinational ROM, buffers {pc, instr}
// pairs in a small prefetch queue and hands them to decode over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_adr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic pop;
  logic push;

  // The two low redirect bits are dropped; the name keeps lint from flagging them.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc_i[1:0];

  assign imem_adr_o    = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];

  // A full queue can still accept a word when decode drains the head in the same cycle.
  assign pop  = instr_valid_o & instr_ready_i;
  assign push = ~redirect_i & ((count_q < cnt_t'(DEPTH)) | pop);

  // NOTE: every _d gets its hold value first, so no path through this block leaves a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + ptr_t'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // NOTE: state uses non-blocking assignments and a reset sampled only on the clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule
